residual_add_norm: RTL
======================

Name: residual_add_norm

Overview:
Post-MLP stage that consumes the MLP output tensor (L,N,E) together with the block input x (the residual path). For each token it forms the saturating residual sum x + mlp and, optionally, subtracts the per-token mean (a centering pre-step of LayerNorm). It processes tokens sequentially, one element per cycle, and emits the full packed tensor with a done/out_valid handshake that matches the MLP block's interface.

Parameters:
DATA_WIDTH, 16, element width; signed two's complement.
L, 8, sequence length.
N, 1, batch size.
E, 8, embedding dimension; must be a power of 2, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  run request; sampled only in S_IDLE
x_in  in  DATA_WIDTH*L*N*E  residual input; element (l,n,e) at bits [((l*N*E)+(n*E)+e+1)*DATA_WIDTH-1 -: DATA_WIDTH]
mlp_in  in  DATA_WIDTH*L*N*E  MLP output; same packing as x_in
out_res  out  DATA_WIDTH*L*N*E  result; same packing
out_valid  out  1  out_res holds a complete result
done  out  1  one-cycle pulse at completion
busy  out  1  high in every state except S_IDLE
sat_flag  out  1  sticky: a saturation occurred during the current or last run

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset, all outputs go to 0 and state goes to S_IDLE. Reset asserted mid-run aborts the run immediately; no partial result is published.
- Let T = L*N tokens, token index t = l*N+n, and SW = DATA_WIDTH + log2(E) (accumulator width, signed).
- States: S_IDLE, S_ADD, S_CENTER, S_DONE.
- S_IDLE:
  - On start=1 at a clock edge: register x_in and mlp_in into internal copies (later input changes are ignored).
  - At the same edge: clear out_valid and sat_flag; set tok=0, idx=0, acc=0; go to S_ADD.
  - start=0: hold. out_res keeps its last value.
- S_ADD, one element per cycle:
  - s = sat(x[tok][idx] + mlp[tok][idx]). Saturation clamps to 0x7FFF / 0x8000 for DATA_WIDTH=16 and sets sat_flag.
  - Store s in the token buffer; acc += sign-extended s.
  - If idx==E-1: set idx=0 and go to S_CENTER; otherwise idx++.
- S_CENTER, one element per cycle:
  - mean = acc >>> log2(E). This is an arithmetic shift, so it floors toward -inf; take the low DATA_WIDTH bits, which always fit.
  - Output element = sat(buf[idx] - mean); a saturation here also sets sat_flag. Write it into the output holding register at position (tok, idx).
  - If idx==E-1: clear acc and idx. Then if tok==T-1 go to S_DONE; otherwise tok++ and go to S_ADD. Otherwise idx++.
- S_DONE:
  - Copy the holding register to out_res; out_valid<=1; done<=1 for exactly one cycle; go to S_IDLE.
  - out_valid stays 1 until the next accepted start.
- Latency: with the start edge numbered 0, done and out_valid are first high after edge 2*T*E+1 (129 for the defaults).
- start while busy: ignored, with no queuing. start held high continuously: a new run begins the cycle after done.
- Saturation, mean and centering are exact per the rules above; there is no rounding other than the floor from the shift.

Optional Feature:
RESADD_MEAN_CENTER_EN
- Defined: behaviour exactly as above; latency 2*T*E+1.
- Not defined: S_CENTER and the accumulator are not built. In S_ADD, s is written directly to the output holding register; after E-1 the FSM moves to the next token, or to S_DONE after the last one. Output is the pure saturating residual sum; latency is T*E+1 (65 for the defaults). sat_flag reflects add saturation only.

Test Plan:
- Defaults, macro on. Token 0: x=0x0010 in all lanes, mlp lane e = e. Sums are 16..23, acc=156, mean=19; outputs are 0xFFFD, 0xFFFE, 0xFFFF, 0, 1, 2, 3, 4. done pulses after edge 129; sat_flag=0.
- Negative floor. Token: sums are -5 in 7 lanes and -6 in lane 0. acc=-41, mean=-6; outputs are 0 in lane 0 and 1 elsewhere.
- Saturation. x=0x7FF0, mlp=0x0100 in all lanes, macro off. Every out element is 0x7FFF, sat_flag=1, done after edge 65. Repeat with x=0x8010, mlp=0xFF00: output 0x8000.
- Start during busy. Pulse start again at cycle 10 with different inputs: ignored, result unchanged, exactly one done. Held-high start: a second run begins the cycle after done and out_valid drops at that edge.
- Reset mid-run. Assert rst_n=0 at cycle 40: outputs are 0 immediately and the state is S_IDLE. After release, a fresh start produces the correct result with no residue from the aborted run.
- Input change after start. Modify x_in/mlp_in one cycle after start: out_res matches the values captured at the start edge.

Source files
------------

// File: rtl/residual_add_norm_if.sv
// Bus bundle for residual_add_norm: run request, packed input tensors and
// the packed result with its completion/status flags.
interface residual_add_norm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
);
  localparam int W = DATA_WIDTH * L * N * E;

  logic         start;
  logic [W-1:0] x_in;
  logic [W-1:0] mlp_in;
  logic [W-1:0] out_res;
  logic         out_valid;
  logic         done;
  logic         busy;
  logic         sat_flag;

  modport master (
    output start, x_in, mlp_in,
    input  out_res, out_valid, done, busy, sat_flag
  );

  modport slave (
    input  start, x_in, mlp_in,
    output out_res, out_valid, done, busy, sat_flag
  );
endinterface

// File: rtl/residual_add_norm.sv
// residual_add_norm: per-token saturating residual sum x + mlp, one element
// per cycle, optionally followed by subtraction of the per-token mean.
// Optional feature macro: RESADD_MEAN_CENTER_EN (mean centering pass).
module residual_add_norm #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  residual_add_norm_if.slave    bus
);
  localparam int T    = L * N;
  localparam int W    = DATA_WIDTH * T * E;
  localparam int LOGE = $clog2(E);
  localparam int TW   = (T > 1) ? $clog2(T) : 1;
`ifdef RESADD_MEAN_CENTER_EN
  localparam int SW   = DATA_WIDTH + LOGE;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_CENTER = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_busy;

  logic [W-1:0]          r_x;
  logic [W-1:0]          r_mlp;
  logic [W-1:0]          r_hold;
  logic [W-1:0]          r_out;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_sat;
  logic [TW-1:0]         r_tok;
  logic [LOGE-1:0]       r_idx;

  logic [31:0]           w_pos;
  logic                  w_last_idx;
  logic                  w_last_tok;
  logic [DATA_WIDTH-1:0] w_x_el;
  logic [DATA_WIDTH-1:0] w_m_el;
  logic [DATA_WIDTH:0]   w_add_ext;
  logic                  w_add_ovf;
  logic [DATA_WIDTH-1:0] w_add_s;

`ifdef RESADD_MEAN_CENTER_EN
  logic signed [SW-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_buf [E];
  logic [DATA_WIDTH-1:0] w_mean;
  logic [DATA_WIDTH:0]   w_sub_ext;
  logic                  w_sub_ovf;
  logic [DATA_WIDTH-1:0] w_sub_s;
`endif

  // Element addressing and saturating arithmetic for the current (tok, idx)
  always_comb begin
    w_pos      = 32'(r_tok) * 32'(E) + 32'(r_idx);
    w_last_idx = (r_idx == LOGE'(E - 1));
    w_last_tok = (r_tok == TW'(T - 1));
    w_x_el     = r_x[w_pos * DATA_WIDTH +: DATA_WIDTH];
    w_m_el     = r_mlp[w_pos * DATA_WIDTH +: DATA_WIDTH];
    w_add_ext  = {w_x_el[DATA_WIDTH-1], w_x_el} + {w_m_el[DATA_WIDTH-1], w_m_el};
    w_add_ovf  = w_add_ext[DATA_WIDTH] ^ w_add_ext[DATA_WIDTH-1];
    if (w_add_ovf)
      w_add_s = w_add_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      w_add_s = w_add_ext[DATA_WIDTH-1:0];
`ifdef RESADD_MEAN_CENTER_EN
    // acc >>> log2(E), truncated to DATA_WIDTH, is exactly the upper slice
    w_mean    = r_acc[SW-1:LOGE];
    w_sub_ext = {r_buf[r_idx][DATA_WIDTH-1], r_buf[r_idx]} - {w_mean[DATA_WIDTH-1], w_mean};
    w_sub_ovf = w_sub_ext[DATA_WIDTH] ^ w_sub_ext[DATA_WIDTH-1];
    if (w_sub_ovf)
      w_sub_s = w_sub_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      w_sub_s = w_sub_ext[DATA_WIDTH-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and busy decode
  always_comb begin
    w_next = r_state;
    w_busy = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_ADD;
      S_ADD: begin
        if (w_last_idx) begin
`ifdef RESADD_MEAN_CENTER_EN
          w_next = S_CENTER;
`else
          w_next = w_last_tok ? S_DONE : S_ADD;
`endif
        end
      end
      S_CENTER: if (w_last_idx) w_next = w_last_tok ? S_DONE : S_ADD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, per-element add/center, result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_mlp   <= '0;
      r_hold  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      r_tok   <= '0;
      r_idx   <= '0;
`ifdef RESADD_MEAN_CENTER_EN
      r_acc   <= '0;
      for (int unsigned i = 0; i < E; i++) r_buf[i] <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x     <= bus.x_in;
            r_mlp   <= bus.mlp_in;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_tok   <= '0;
            r_idx   <= '0;
`ifdef RESADD_MEAN_CENTER_EN
            r_acc   <= '0;
`endif
          end
        end
        S_ADD: begin
          if (w_add_ovf) r_sat <= 1'b1;
`ifdef RESADD_MEAN_CENTER_EN
          r_buf[r_idx] <= w_add_s;
          r_acc        <= r_acc + {{LOGE{w_add_s[DATA_WIDTH-1]}}, w_add_s};
          r_idx        <= w_last_idx ? '0 : r_idx + 1'b1;
`else
          r_hold[w_pos * DATA_WIDTH +: DATA_WIDTH] <= w_add_s;
          if (w_last_idx) begin
            r_idx <= '0;
            if (!w_last_tok) r_tok <= r_tok + 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`endif
        end
`ifdef RESADD_MEAN_CENTER_EN
        S_CENTER: begin
          if (w_sub_ovf) r_sat <= 1'b1;
          r_hold[w_pos * DATA_WIDTH +: DATA_WIDTH] <= w_sub_s;
          if (w_last_idx) begin
            r_idx <= '0;
            r_acc <= '0;
            if (!w_last_tok) r_tok <= r_tok + 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_out   <= r_hold;
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_res   = r_out;
  assign bus.out_valid = r_valid;
  assign bus.done      = r_done;
  assign bus.busy      = w_busy;
  assign bus.sat_flag  = r_sat;

endmodule
